cu_wb: RTL

Write-back stage of the control unit. It consumes the raw 32-bit word produced by the memory stage, together with the ALU result and PC+4 carried down the pipe. It selects the write-back source and applies load byte-lane alignment with sign/zero extension. It then issues a single-cycle register-file write. A small stage FSM gives fixed two-cycle latency from `wb_start` to commit, with stall and reset handling that matches the memory stage.

---
 rtl/cu_wb.sv | 92 +++++++++
 1 files changed

// File: rtl/cu_wb.sv
// cu_wb: control-unit write-back stage with load alignment/extension and fixed two-cycle commit latency
//   soc_clk, WB_reset (sync, active-high), WB_stall (freezes all state)
//   wb_start + MEM_data/alu_result/pc_plus4/addr_lo/funct3/wb_sel/rd : latched in IDLE
//   rf_we/rf_waddr/rf_wdata : register-file write, rf_we one cycle in COMMIT
//   wb_busy (not IDLE), wb_done (commit pulse), wb_trap (misaligned load)
//   Optional macro CU_WB_MISALIGN_TRAP_EN enables misaligned-load trapping; otherwise wb_trap is 0.
module cu_wb #(
   parameter int XLEN = 32
) (
   input  logic            soc_clk,
   input  logic            WB_reset,
   input  logic            WB_stall,
   input  logic            wb_start,
   input  logic [XLEN-1:0] MEM_data,
   input  logic [XLEN-1:0] alu_result,
   input  logic [XLEN-1:0] pc_plus4,
   input  logic [1:0]      addr_lo,
   input  logic [2:0]      funct3,
   input  logic [1:0]      wb_sel,
   input  logic [4:0]      rd,
   output logic            rf_we,
   output logic [4:0]      rf_waddr,
   output logic [XLEN-1:0] rf_wdata,
   output logic            wb_busy,
   output logic            wb_done,
   output logic            wb_trap
);
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] FORMAT = 2'd1;
   localparam logic [1:0] COMMIT = 2'd2;
   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] mem_q, alu_q, pc_q, wdata_q, wdata_d;
   logic [1:0]      lo_q, sel_q;
   logic [2:0]      f3_q;
   logic [4:0]      rd_q, waddr_q;
   logic [7:0]      byte_v;
   logic [15:0]     half_v;
   logic [XLEN-1:0] load_v;
   logic            trap_c, commit;
   always_comb begin
      byte_v  = 8'(mem_q >> {lo_q, 3'b000});
      half_v  = 16'(mem_q >> {lo_q[1], 4'b0000});
      load_v  = f3_q == 3'b000 ? {{24{byte_v[7]}}, byte_v} :
                f3_q == 3'b001 ? {{16{half_v[15]}}, half_v} :
                f3_q == 3'b100 ? {24'd0, byte_v} :
                f3_q == 3'b101 ? {16'd0, half_v} : mem_q;
      wdata_d = sel_q == 2'b00 ? alu_q : sel_q == 2'b01 ? load_v : pc_q;
`ifdef CU_WB_MISALIGN_TRAP_EN
      // funct3[1:0]: 00 byte (never misaligned), 01 half, else word (undefined codes act as LW)
      trap_c  = sel_q == 2'b01 && (f3_q[1:0] == 2'b00 ? 1'b0 : f3_q[1:0] == 2'b01 ? lo_q[0] : |lo_q);
`else
      trap_c  = 1'b0;
`endif
      commit  = state_q == COMMIT && !WB_stall;
      rf_we   = commit && rd_q != 5'd0 && sel_q != 2'b11 && !trap_c;
      wb_done = commit;
      wb_trap = commit && trap_c;
      wb_busy = state_q != IDLE;
      state_d = state_q == IDLE ? (wb_start ? FORMAT : IDLE) : state_q == FORMAT ? COMMIT : IDLE;
   end
   always_ff @(posedge soc_clk) begin
      if (WB_reset) begin
         state_q <= IDLE;
         waddr_q <= '0;
         wdata_q <= '0;
         mem_q   <= '0;
         alu_q   <= '0;
         pc_q    <= '0;
         lo_q    <= '0;
         f3_q    <= '0;
         sel_q   <= '0;
         rd_q    <= '0;
      end else if (!WB_stall) begin
         state_q <= state_d;
         if (state_q == IDLE && wb_start) begin
            mem_q <= MEM_data;
            alu_q <= alu_result;
            pc_q  <= pc_plus4;
            lo_q  <= addr_lo;
            f3_q  <= funct3;
            sel_q <= wb_sel;
            rd_q  <= rd;
         end
         if (state_q == FORMAT) begin
            waddr_q <= rd_q;
            wdata_q <= wdata_d;
         end
      end
   end
   assign rf_waddr = waddr_q;
   assign rf_wdata = wdata_q;
endmodule
